// File: rtl/conv_sched_pkg.sv
// Shared state encoding and sample limits for the convolution scheduler.
package conv_sched_pkg;

    localparam int RESULT_W = 48;

    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        WAIT_IR,
        READY,
        ISSUE,
        WAIT_RESULT,
        EMIT
    } sched_state_t;

endpackage

// File: rtl/conv_result_saturate.sv
// Registered arithmetic right shift and clamp of a wide convolver result
// down to a 16-bit signed audio sample.
module conv_result_saturate #(
    parameter int RESULT_W = conv_sched_pkg::RESULT_W
) (
    input  logic                       audio_clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic signed [RESULT_W-1:0] value,
    input  logic [5:0]                 shift,
    output logic signed [15:0]         sample,
    output logic                       sample_vld
);
    import conv_sched_pkg::*;

    localparam logic [5:0] SHIFT_MAX = 6'(RESULT_W - 1);
    localparam logic signed [RESULT_W-1:0] MAX_EXT = {{(RESULT_W-16){1'b0}}, SAMPLE_MAX};
    localparam logic signed [RESULT_W-1:0] MIN_EXT = {{(RESULT_W-16){1'b1}}, SAMPLE_MIN};

    function automatic logic signed [15:0] sat16(input logic signed [RESULT_W-1:0] x);
        if (x > MAX_EXT) return SAMPLE_MAX;
        if (x < MIN_EXT) return SAMPLE_MIN;
        return $signed(x[15:0]);
    endfunction

    logic [5:0]                 shamt_p0;
    logic signed [RESULT_W-1:0] shifted_p0;
    logic signed [15:0]         sample_p1;
    logic                       vld_p1;

    assign shamt_p0   = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
    assign shifted_p0 = value >>> shamt_p0;

    // p0 -> p1: clamp the full-width shifted value and hold it until the next load
    always_ff @(posedge audio_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            sample_p1 <= '0;
        end else begin
            vld_p1 <= load;
            if (load) sample_p1 <= sat16(shifted_p0);
        end
    end

    assign sample     = sample_p1;
    assign sample_vld = vld_p1;

endmodule

// File: rtl/convolve_scheduler.sv
// Sequences audio samples into the convolution engine and scales its result.
// Build option: CONV_SCHED_DRY_BYPASS_EN passes input samples straight through while the IR is not ready.
module convolve_scheduler #(
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int RESULT_W       = conv_sched_pkg::RESULT_W
) (
    input  logic                       audio_clk,
    input  logic                       rst_in_n,
    input  logic                       sample_valid_in,
    input  logic signed [15:0]         sample_in,
    input  logic                       ir_ready_in,
    input  logic [5:0]                 shift_in,
    output logic                       conv_trigger_out,
    output logic signed [15:0]         conv_sample_out,
    input  logic                       conv_done_in,
    input  logic signed [RESULT_W-1:0] conv_result_in,
    output logic signed [15:0]         audio_out,
    output logic                       audio_out_valid,
    output logic [15:0]                overrun_count,
    output logic                       timeout_flag
);
    import conv_sched_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t               state, state_nxt;
    logic                       pend_full;
    logic signed [15:0]         pend_data;
    logic [CNT_W-1:0]           tmo_cnt;
    logic                       tmo_seen;
    logic                       tmo_hit;
    logic                       go_issue;
    logic                       flush;
    logic                       strobe_busy;
    logic                       pend_fill;
    logic                       sat_load;
    logic signed [RESULT_W-1:0] sat_value;
    logic [5:0]                 sat_shift;

    assign go_issue    = (state == READY) && ir_ready_in && (pend_full || sample_valid_in);
    assign tmo_hit     = (state == WAIT_RESULT) && !conv_done_in && (tmo_cnt == CNT_LAST);
    assign flush       = (state == WAIT_IR) || ((state == EMIT) && !ir_ready_in);
    assign strobe_busy = sample_valid_in && !flush && (state != READY);
    assign pend_fill   = (strobe_busy && !pend_full) || (go_issue && pend_full && sample_valid_in);

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) state <= WAIT_IR;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_IR:     if (ir_ready_in) state_nxt = READY;
            READY: begin
                if (!ir_ready_in)  state_nxt = WAIT_IR;
                else if (go_issue) state_nxt = ISSUE;
            end
            ISSUE:       state_nxt = WAIT_RESULT;
            WAIT_RESULT: if (conv_done_in || tmo_hit) state_nxt = EMIT;
            EMIT:        state_nxt = ir_ready_in ? READY : WAIT_IR;
            default:     state_nxt = WAIT_IR;
        endcase
    end

    always_comb begin
        conv_trigger_out = (state == ISSUE);
        timeout_flag     = tmo_seen || tmo_hit;
    end

    // One-deep pending slot; a strobe that finds it occupied is dropped and counted
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            pend_full     <= 1'b0;
            overrun_count <= '0;
        end else if (flush) begin
            pend_full <= 1'b0;
        end else if (go_issue) begin
            pend_full <= pend_full && sample_valid_in;
        end else if (strobe_busy) begin
            if (!pend_full)                        pend_full     <= 1'b1;
            else if (overrun_count != 16'hFFFF)    overrun_count <= overrun_count + 16'd1;
        end
    end

    always_ff @(posedge audio_clk) begin
        if (pend_fill) pend_data <= sample_in;
    end

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n)     conv_sample_out <= '0;
        else if (go_issue) conv_sample_out <= pend_full ? pend_data : sample_in;
    end

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            tmo_cnt  <= '0;
            tmo_seen <= 1'b0;
        end else begin
            if (state == ISSUE)            tmo_cnt <= '0;
            else if (state == WAIT_RESULT) tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (tmo_hit) tmo_seen <= 1'b1;
        end
    end

    // A timed-out convolution still emits, with a forced zero result
    always_comb begin
        sat_load  = (state == WAIT_RESULT) && (conv_done_in || tmo_hit);
        sat_value = conv_done_in ? conv_result_in : '0;
        sat_shift = shift_in;
`ifdef CONV_SCHED_DRY_BYPASS_EN
        if ((state == WAIT_IR) && sample_valid_in) begin
            sat_load  = 1'b1;
            sat_value = {{(RESULT_W-16){sample_in[15]}}, sample_in};
            sat_shift = '0;
        end
`endif
    end

    conv_result_saturate #(
        .RESULT_W (RESULT_W)
    ) u_sat (
        .audio_clk  (audio_clk),
        .rst_n      (rst_in_n),
        .load       (sat_load),
        .value      (sat_value),
        .shift      (sat_shift),
        .sample     (audio_out),
        .sample_vld (audio_out_valid)
    );

endmodule

// File: doc/convolve_scheduler.md
# convolve_scheduler

Sequencer between the I2S/sample-rate domain logic and the 8-lane convolution engine. Accepts one audio sample per sample strobe and gates it on the impulse-memory-ready flag. It issues the convolver trigger and holds the sample stable, waits for the 48-bit result, then scales and saturates it to a 16-bit output sample. It absorbs one sample of overrun, counts dropped samples and recovers from a convolver that never answers.

## Interface
- TIMEOUT_CYCLES, 8192: max cycles from trigger to result before abort.
- RESULT_W, 48: width of convolver result.
- audio_clk  in  1  system audio clock; all logic on rising edge.
- rst_in_n  in  1  asynchronous, active-low reset.
- sample_valid_in  in  1  one-cycle strobe, new input sample.
- sample_in  in  16  signed input sample, valid with strobe.
- ir_ready_in  in  1  level; impulse response fully loaded.
- shift_in  in  6  arithmetic right shift applied to result (0..47; >47 treated as 47).
- conv_trigger_out  out  1  one-cycle pulse starting a convolution.
- conv_sample_out  out  16  sample presented to convolver; held from trigger until result.
- conv_done_in  in  1  convolver result-valid pulse.
- conv_result_in  in  RESULT_W  signed convolver accumulation, valid with conv_done_in.
- audio_out  out  16  signed saturated output sample; holds last value.
- audio_out_valid  out  1  one-cycle pulse, new audio_out.
- overrun_count  out  16  saturating count of dropped input samples.
- timeout_flag  out  1  sticky; set on any convolver timeout, cleared only by reset.

## Operation
- States: WAIT_IR, READY, ISSUE, WAIT_RESULT, EMIT.
- WAIT_IR: entered on reset and whenever ir_ready_in is low outside WAIT_RESULT. Samples are not queued. Output behaviour depends on the config macro. Go to READY when ir_ready_in is high.
- READY: if pending buffer is full, or sample_valid_in is high, go to ISSUE. A simultaneous strobe with a full pending buffer keeps the pending (older) sample and loads the new one into pending.
- ISSUE: conv_sample_out <= the selected sample; conv_trigger_out high for exactly this cycle; timeout counter cleared; go to WAIT_RESULT.
- WAIT_RESULT: count cycles. On conv_done_in go to EMIT. If the count reaches TIMEOUT_CYCLES, set timeout_flag, force the result to 0 and go to EMIT.
- EMIT: audio_out <= sat16(result >>> shift). Pulse audio_out_valid. Go to READY, or to WAIT_IR if ir_ready_in is low.
- Pending buffer holds 1 sample. A strobe outside READY fills it if empty. If it is already full, the new sample is dropped and overrun_count increments, saturating at 16'hFFFF.
- sat16: clamp to [-32768, 32767] using the full shifted width. The shift is arithmetic (sign-extending).
- ir_ready_in falling during WAIT_RESULT: the result is still awaited and emitted, then the block goes to WAIT_IR and the pending buffer is flushed without counting.

## Timing
- Reset values: conv_trigger_out 0, conv_sample_out 0, audio_out 0, audio_out_valid 0, overrun_count 0, timeout_flag 0. Pending buffer empty; state WAIT_IR.
- Strobe in READY at cycle t: ISSUE at t+1, conv_trigger_out high at t+1.
- conv_done_in at cycle d: audio_out and audio_out_valid update at d+1.
- READY at d+2. The earliest next trigger is d+3. The convolver is always idle for at least 2 cycles before re-trigger.
- conv_sample_out is stable from trigger until EMIT.
- conv_done_in outside WAIT_RESULT is ignored.
- Timeout fires on cycle trigger+TIMEOUT_CYCLES. audio_out_valid with value 0 follows one cycle later.

## Configuration
- CONV_SCHED_DRY_BYPASS_EN defined: in WAIT_IR, every sample_valid_in produces audio_out = sample_in with audio_out_valid on the next cycle (dry passthrough).
- CONV_SCHED_DRY_BYPASS_EN undefined: in WAIT_IR, inputs are ignored and audio_out/audio_out_valid stay unchanged.

## Structure
- Package conv_sched_pkg holds the state enum typedef, RESULT_W and the 16-bit sample min/max constants.
- Sub-module conv_result_saturate: registered shift-and-clamp stage, RESULT_W in, 16 out. Its latency is absorbed in the EMIT cycle (inputs registered at done).

## Test plan
- Reset, then ir_ready_in=1 and sample 0x1234 strobe -> conv_trigger_out pulse next cycle, conv_sample_out=0x1234 held. conv_done_in with result 0x0000_1234_0000 and shift 16 -> audio_out=0x1234, valid pulse one cycle later.
- Result 48'sh7FFF_FFFF_FFFF with shift 0 -> audio_out=0x7FFF. Result -48'sd1_000_000 with shift 4 -> audio_out=0x8000 (-62500 clamps).
- Three strobes during one WAIT_RESULT -> first queued, second and third dropped; overrun_count=2. The queued sample is triggered at done+3.
- No conv_done_in with TIMEOUT_CYCLES=64 -> timeout_flag=1 at trigger+64, audio_out=0 valid, then a normal next cycle.
- ir_ready_in low at reset, strobe 0x0ABC -> with the macro, audio_out=0x0ABC next cycle; without it, no valid pulse and no trigger.
- rst_in_n asserted mid-WAIT_RESULT -> all outputs return to reset values immediately. The later conv_done_in is ignored.
